// File: rtl/ddr3_pkg.sv
// Shared definitions for the DTR temperature monitor: FSM state encoding and
// the field layout of the DTROUT bus.
package ddr3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        CONV    = 2'd2,
        CAPTURE = 2'd3
    } dtr_state_t;

    localparam int DTR_CODE_W    = 6;
    localparam int DTR_VALID_BIT = 7;

endpackage

// File: rtl/dtr_temp_monitor_if.sv
// Signal bundle between the temperature monitor, the DTR primitive and the
// refresh scheduler. The monitor takes the master view.
interface dtr_temp_monitor_if;
    import ddr3_pkg::*;

    logic                  force_req;
    logic [7:0]            dtr_out;
    logic                  dtr_startpulse;
    logic                  busy;
    logic [DTR_CODE_W-1:0] temp_code;
    logic                  temp_valid;
    logic                  temp_ok;
    logic                  hot;
    logic                  err;

    modport master (
        input  force_req, dtr_out,
        output dtr_startpulse, busy, temp_code, temp_valid, temp_ok, hot, err
    );

    modport slave (
        output force_req, dtr_out,
        input  dtr_startpulse, busy, temp_code, temp_valid, temp_ok, hot, err
    );
endinterface

// File: rtl/dtr_sync2.sv
// Generic two-flop synchronizer for bringing a quasi-static bus into the clk
// domain.
module dtr_sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; the first may go metastable, the second resolves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dtr_temp_monitor.sv
// Periodic controller for the ECP5 DTR block: issues the start pulse, times
// the conversion, captures the 6-bit code and keeps a hysteretic hot flag.
// Optional macro DTR_SYNC_EN: route dtr_out through a 2-flop synchronizer and
// stretch the conversion window by the two extra clocks of latency.
module dtr_temp_monitor
    import ddr3_pkg::*;
#(
    parameter int unsigned           PERIOD_CYCLES = 1000000,
    parameter int unsigned           PULSE_CYCLES  = 16,
    parameter int unsigned           CONV_CYCLES   = 8000,
    parameter logic [DTR_CODE_W-1:0] HOT_SET       = 6'd42,
    parameter logic [DTR_CODE_W-1:0] HOT_CLR       = 6'd38
) (
    input logic                clk,
    input logic                rst,
    dtr_temp_monitor_if.master bus
);

`ifdef DTR_SYNC_EN
    localparam int unsigned CONV_TOTAL = CONV_CYCLES + 2;
`else
    localparam int unsigned CONV_TOTAL = CONV_CYCLES;
`endif

    localparam int unsigned PERIOD_W = $clog2(PERIOD_CYCLES + 1);
    localparam int unsigned PULSE_W  = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned CONV_W   = $clog2(CONV_TOTAL + 1);

    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CYCLES - 1);
    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [CONV_W-1:0]   CONV_LAST   = CONV_W'(CONV_TOTAL - 1);

    dtr_state_t            state;
    logic [PERIOD_W-1:0]   period_cnt;
    logic [PULSE_W-1:0]    pulse_cnt;
    logic [CONV_W-1:0]     conv_cnt;
    logic                  pend;
    logic                  tick;
    logic                  request;
    logic [7:0]            dtr_in;
    logic [DTR_CODE_W-1:0] code;

    logic                  startpulse_q;
    logic                  busy_q;
    logic [DTR_CODE_W-1:0] temp_code_q;
    logic                  temp_valid_q;
    logic                  temp_ok_q;
    logic                  hot_q;
    logic                  err_q;

`ifdef DTR_SYNC_EN
    dtr_sync2 #(.WIDTH(8)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.dtr_out),
        .q   (dtr_in)
    );
`else
    assign dtr_in = bus.dtr_out;
`endif

    // Bit 6 of DTROUT carries nothing useful.
    logic unused_dtr_bit;
    assign unused_dtr_bit = dtr_in[6];

    assign code    = dtr_in[DTR_CODE_W-1:0];
    assign tick    = (period_cnt == PERIOD_LAST);
    assign request = tick | bus.force_req;

    // Free-running period timer; the tick is the cycle that wraps it to zero.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples pre-edge values.
        if (rst) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
        end
    end

    // Conversion sequencer with pending-request latch and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pulse_cnt    <= '0;
            conv_cnt     <= '0;
            pend         <= 1'b0;
            startpulse_q <= 1'b0;
            busy_q       <= 1'b0;
            temp_code_q  <= '0;
            temp_valid_q <= 1'b0;
            temp_ok_q    <= 1'b0;
            hot_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            temp_valid_q <= 1'b0;

            // Requests seen while a conversion is in flight collapse into one.
            if (state != IDLE && request) begin
                pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (request || pend) begin
                        state        <= PULSE;
                        startpulse_q <= 1'b1;
                        busy_q       <= 1'b1;
                        pulse_cnt    <= '0;
                        // Leaving on a pended request: a fresh request this cycle stays queued.
                        pend         <= pend & request;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state        <= CONV;
                        startpulse_q <= 1'b0;
                        conv_cnt     <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PULSE_W'(1);
                    end
                end
                CONV: begin
                    if (conv_cnt == CONV_LAST) begin
                        if (dtr_in[DTR_VALID_BIT]) begin
                            state <= CAPTURE;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                        end
                    end else begin
                        conv_cnt <= conv_cnt + CONV_W'(1);
                    end
                end
                CAPTURE: begin
                    state        <= IDLE;
                    busy_q       <= 1'b0;
                    temp_code_q  <= code;
                    temp_valid_q <= 1'b1;
                    temp_ok_q    <= 1'b1;
                    err_q        <= 1'b0;
                    if (code >= HOT_SET) begin
                        hot_q <= 1'b1;
                    end else if (code <= HOT_CLR) begin
                        hot_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dtr_startpulse = startpulse_q;
    assign bus.busy           = busy_q;
    assign bus.temp_code      = temp_code_q;
    assign bus.temp_valid     = temp_valid_q;
    assign bus.temp_ok        = temp_ok_q;
    assign bus.hot            = hot_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_dtr_temp_monitor.sv
// Directed bench for dtr_temp_monitor with a behavioural DTR stub.
// cyc mirrors the DUT period counter (both restart on rst), so tick edges
// fall at cyc = 200, 400, 600, ...
module tb_dtr_temp_monitor;
    import ddr3_pkg::*;

    localparam int PERIOD = 200;
    localparam int PULSE  = 4;
    localparam int CONV   = 50;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;

    logic [5:0] stub_code;
    int         stub_delay;
    int         stub_cnt;
    logic       stub_run;
    logic       prev_sp;

    dtr_temp_monitor_if bus ();

    dtr_temp_monitor #(
        .PERIOD_CYCLES (PERIOD),
        .PULSE_CYCLES  (PULSE),
        .CONV_CYCLES   (CONV),
        .HOT_SET       (6'd42),
        .HOT_CLR       (6'd38)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // DTR stub: valid clears while STARTPULSE is high; after the falling
    // edge the code appears stub_delay clocks later. Bit 6 is kept at 1.
    always @(posedge clk) begin
        if (rst) begin
            prev_sp     <= 1'b0;
            stub_run    <= 1'b0;
            stub_cnt    <= 0;
            bus.dtr_out <= 8'h40;
        end else begin
            prev_sp <= bus.dtr_startpulse;
            if (bus.dtr_startpulse) begin
                stub_run    <= 1'b0;
                bus.dtr_out <= 8'h40;
            end else if (prev_sp) begin
                stub_run <= 1'b1;
                stub_cnt <= 1;
            end else if (stub_run) begin
                if (stub_cnt >= stub_delay) begin
                    bus.dtr_out <= {2'b11, stub_code};
                    stub_run    <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_startpulse"}, 32'(bus.dtr_startpulse), 0);
        check({tag, "_busy"},       32'(bus.busy),           0);
        check({tag, "_temp_code"},  32'(bus.temp_code),      0);
        check({tag, "_temp_valid"}, 32'(bus.temp_valid),     0);
        check({tag, "_temp_ok"},    32'(bus.temp_ok),        0);
        check({tag, "_hot"},        32'(bus.hot),            0);
        check({tag, "_err"},        32'(bus.err),            0);
    endtask

    task automatic wait_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) check("wait_cyc_reached", 32'(cyc), 32'(c));
    endtask

    task automatic force_at(input int c);
        wait_cyc(c);
        bus.force_req = 1'b1;
        @(negedge clk);
        bus.force_req = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.temp_valid === 1'b1) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic watch(input int n, output int n_valid, output int n_start);
        n_valid = 0;
        n_start = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.temp_valid !== 1'b0) n_valid++;
            if (bus.dtr_startpulse !== 1'b0) n_start++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int width;
        int nv;
        int ns;
        int e_at;

        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.force_req = 1'b0;
        stub_code     = 6'd25;
        stub_delay    = 30;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Basic capture: start after edge 3, capture strobe 55 clocks later.
        force_at(2);
        check("basic_rise", 32'(bus.dtr_startpulse), 1);
        check("basic_busy", 32'(bus.busy), 1);
        width = 0;
        while (bus.dtr_startpulse === 1'b1 && width < 20) begin
            width++;
            @(negedge clk);
        end
        check("basic_pulse_width", 32'(width), 4);
        wait_valid(100, at);
        check("basic_valid_cyc", 32'(at), 58);
        check("basic_code", 32'(bus.temp_code), 25);
        check("basic_ok", 32'(bus.temp_ok), 1);
        check("basic_hot", 32'(bus.hot), 0);
        check("basic_err", 32'(bus.err), 0);
        @(negedge clk);
        check("basic_valid_one_cycle", 32'(bus.temp_valid), 0);
        check("basic_idle", 32'(bus.busy), 0);

        // Hysteresis 42, 40, 38 (via period tick at 200), 41.
        stub_code = 6'd42;
        force_at(60);
        wait_valid(100, at);
        check("hyst42_cyc", 32'(at), 116);
        check("hyst42_hot", 32'(bus.hot), 1);
        @(negedge clk);
        stub_code = 6'd40;
        force_at(118);
        wait_valid(100, at);
        check("hyst40_cyc", 32'(at), 174);
        check("hyst40_hot", 32'(bus.hot), 1);
        @(negedge clk);
        stub_code = 6'd38;
        wait_valid(150, at);
        check("hyst38_tick_cyc", 32'(at), 255);
        check("hyst38_code", 32'(bus.temp_code), 38);
        check("hyst38_hot", 32'(bus.hot), 0);
        @(negedge clk);
        stub_code = 6'd41;
        force_at(258);
        wait_valid(100, at);
        check("hyst41_cyc", 32'(at), 314);
        check("hyst41_hot", 32'(bus.hot), 0);
        @(negedge clk);

        // Timeout: valid never arrives inside the window.
        stub_code  = 6'd50;
        stub_delay = 80;
        force_at(316);
        nv   = 0;
        e_at = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.temp_valid === 1'b1) nv++;
            if (bus.err === 1'b1) begin
                e_at = cyc;
                break;
            end
            @(negedge clk);
        end
        check("timeout_err_cyc", 32'(e_at), 371);
        check("timeout_no_valid", 32'(nv), 0);
        check("timeout_code_kept", 32'(bus.temp_code), 41);
        check("timeout_hot_kept", 32'(bus.hot), 0);
        check("timeout_idle", 32'(bus.busy), 0);
        stub_code  = 6'd30;
        stub_delay = 30;
        @(negedge clk);
        wait_valid(150, at);
        check("recover_cyc", 32'(at), 455);
        check("recover_err", 32'(bus.err), 0);
        check("recover_code", 32'(bus.temp_code), 30);
        @(negedge clk);

        // Three force requests during CONV collapse into one extra conversion.
        force_at(460);
        force_at(470);
        force_at(480);
        force_at(490);
        wait_valid(100, at);
        check("busyforce_first_cyc", 32'(at), 516);
        @(negedge clk);
        check("busyforce_restart", 32'(bus.dtr_startpulse), 1);
        wait_valid(100, at);
        check("busyforce_second_cyc", 32'(at), 572);
        watch(25, nv, ns);
        check("busyforce_no_third", 32'(ns), 0);

        // force_req in the same IDLE cycle as the tick: a single conversion.
        force_at(599);
        check("simul_rise", 32'(bus.dtr_startpulse), 1);
        wait_valid(100, at);
        check("simul_valid_cyc", 32'(at), 655);
        check("simul_busy_drop", 32'(bus.busy), 0);
        watch(40, nv, ns);
        check("simul_no_second", 32'(ns), 0);

        // Reset during PULSE.
        force_at(700);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_pulse");
        rst = 1'b0;
        watch(80, nv, ns);
        check("rst_pulse_no_valid", 32'(nv), 0);
        check("rst_pulse_no_start", 32'(ns), 0);

        // Reset during CONV, after a capture that sets hot and temp_ok.
        stub_code = 6'd45;
        force_at(82);
        wait_valid(100, at);
        check("pre_rst_cyc", 32'(at), 138);
        check("pre_rst_hot", 32'(bus.hot), 1);
        @(negedge clk);
        force_at(140);
        wait_cyc(160);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_conv");
        rst = 1'b0;
        watch(80, nv, ns);
        check("rst_conv_no_valid", 32'(nv), 0);
        check("rst_conv_no_start", 32'(ns), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dtr_temp_monitor.md
# dtr_temp_monitor

Periodic controller for the ECP5 DTR (digital temperature readout) hard block: generates the DTR start pulse, times the conversion, captures the 6-bit temperature code and derives a hysteretic "hot" flag. Sits directly upstream and downstream of the DTR primitive: drives its `STARTPULSE` and consumes `DTROUT7..0`. The DDR3 refresh scheduler uses `hot` to switch to 2x refresh.

## Interface
- `PERIOD_CYCLES`, 1000000: clocks between automatic conversion starts. Must be greater than `PULSE_CYCLES + CONV_CYCLES + 2`.
- `PULSE_CYCLES`, 16: clocks `dtr_startpulse` is held high. Must be ≥1.
- `CONV_CYCLES`, 8000: clocks allowed after the start-pulse falling edge before the valid bit is checked. Must be ≥1.
- `HOT_SET`, 6'd42: `hot` asserts when the captured code is ≥ this value.
- `HOT_CLR`, 6'd38: `hot` deasserts when the captured code is ≤ this value. Must satisfy `HOT_CLR < HOT_SET`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `force_req`  in  1  single-cycle request for an immediate conversion.
- `dtr_out`  in  8  DTROUT7..0; bit 7 = valid, bit 6 = unused, bits 5:0 = code.
- `dtr_startpulse`  out  1  drives DTR STARTPULSE.
- `busy`  out  1  high in every state except IDLE.
- `temp_code`  out  6  last good captured code.
- `temp_valid`  out  1  one-cycle strobe when `temp_code` updates.
- `temp_ok`  out  1  sticky; set by the first good capture.
- `hot`  out  1  hysteretic over-temperature flag.
- `err`  out  1  set on a conversion timeout; cleared by the next good capture.

## Operation
- FSM states: IDLE, PULSE, CONV, CAPTURE.
- **IDLE → PULSE** when a period tick occurs or `pend` is set. On entry, `dtr_startpulse` goes 1 and `pend` clears.
- **PULSE:** hold `dtr_startpulse` high for exactly `PULSE_CYCLES` clocks. Then drive it 0 and go to CONV. The falling edge starts the DTR conversion.
- **CONV:** the counter runs for `CONV_CYCLES` clocks. On the last cycle, sample `dtr_out[7]`:
  - 1 → go to CAPTURE.
  - 0 → set `err` and go to IDLE. `temp_code` and `hot` are unchanged.
- **CAPTURE** (one cycle):
  - Load `temp_code` from `dtr_out[5:0]`.
  - Pulse `temp_valid`, set `temp_ok`, clear `err`.
  - Update `hot`: set if the code is ≥ `HOT_SET`; clear if it is ≤ `HOT_CLR`; otherwise hold.
  - Return to IDLE.
- **Period timer:** free-running from reset, counts 0..`PERIOD_CYCLES-1`. The tick fires at the wrap.
- **Pending latch:** `pend` is set by a tick or `force_req` that arrives while busy, or that arrives in the same cycle as the IDLE exit. Any number of such requests collapse into one pending conversion.
- **Tick and `force_req` in the same IDLE cycle:** exactly one conversion runs and nothing is pended.
- `dtr_out[6]` is ignored.
- All counters are unsigned, width `$clog2(param+1)`, and never wrap mid-state.

## Timing
- Reset values: `dtr_startpulse`=0, `busy`=0, `temp_code`=0, `temp_valid`=0, `temp_ok`=0, `hot`=0, `err`=0, `pend`=0, FSM=IDLE, timers=0.
- Reset asserted mid-conversion: the FSM returns to IDLE next clock and `dtr_startpulse` drops to 0 immediately. A falling edge caused by reset is tolerated, since its result is never captured.
- Start latency: `dtr_startpulse` rises on the clock after the request cycle.
- Capture latency: `temp_valid` pulses `PULSE_CYCLES + CONV_CYCLES + 1` clocks after `dtr_startpulse` rises. Add 2 clocks when `DTR_SYNC_EN` is defined.
- `temp_code` and `hot` change only in the `temp_valid` cycle and are registered outputs.

## Configuration
- `DTR_SYNC_EN`:
  - **Defined:** `dtr_out` passes through a 2-flop synchronizer before use. CONV is extended by 2 clocks so the sampled value reflects the synchronized input.
  - **Undefined:** `dtr_out` is used directly, and the DTR is treated as synchronous to `clk`.

## Structure
- Shared package `ddr3_pkg` holds:
  - the FSM state enum `dtr_state_t`;
  - `DTR_CODE_W = 6`;
  - `DTR_VALID_BIT = 7`.
- One sub-module, `dtr_sync2`: the generic 2-flop synchronizer, instantiated 8 wide only under `DTR_SYNC_EN`.
- The FSM, timers and hysteresis are inline in `dtr_temp_monitor`.

## Test plan
The bench uses a behavioural DTR stub with a configurable conversion delay. Bench parameters: `PERIOD_CYCLES`=200, `PULSE_CYCLES`=4, `CONV_CYCLES`=50.
- **Basic capture.** Stub code=25, delay=30 → `dtr_startpulse` high 4 clocks; `temp_valid` pulses 55 clocks after the start; `temp_code`=25; `temp_ok`=1; `hot`=0.
- **Hysteresis.** Successive codes 42, 40, 38, 41 → `hot` reads 1, 1, 0, 0 after the respective captures.
- **Timeout.** Stub delay=80 (valid still 0 at the check) → `err`=1, no `temp_valid`, `temp_code` keeps its old value. Next conversion with delay=30 → `err`=0.
- **Force while busy.** Pulse `force_req` three times during CONV → exactly one extra conversion starts the clock after returning to IDLE.
- **Simultaneous requests.** `force_req` in the same cycle as the period tick while IDLE → one conversion only; `busy` drops after capture.
- **Reset mid-operation.** `rst` during PULSE (and separately during CONV) → next clock: all outputs at reset values, FSM in IDLE, no `temp_valid`.
